data_memory_mc: RTL and testbench
=================================

# data_memory_mc

Parametrised multi-cycle data memory for the pipelined CPU's MEM stage. It replaces the zero-latency combinational-read memory with a request/done handshake and a configurable access latency. It also adds width-generic words, byte-enabled writes, and optional alignment checking. The pipeline stalls on `busy` and consumes `data_out` when `done` pulses.

## Interface
- `DATA_WIDTH`, 16: word width in bits; a power-of-two number of bytes, at least 1.
- `ADDR_WIDTH`, 16: byte-address width.
- `LATENCY`, 2: cycles from request acceptance to `done`; at least 1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req` in 1: access request; sampled only when `busy`=0.
- `wr` in 1: 1 = write, 0 = read.
- `addr` in ADDR_WIDTH: byte address.
- `data_in` in DATA_WIDTH: write data.
- `be` in DATA_WIDTH/8: write byte enables; `be[i]` covers bits `8i+7:8i`.
- `busy` out 1: access in flight.
- `done` out 1: one-cycle completion pulse.
- `data_out` out DATA_WIDTH: read data, registered.
- `err` out 1: misaligned-access flag, valid with `done`.

## Operation
- OFS = log2(DATA_WIDTH/8). Word index = `addr[ADDR_WIDTH-1:OFS]`. Depth = 2^(ADDR_WIDTH-OFS) words.
- FSM states:
  - IDLE: `busy`=0. If `req`=1, latch `wr`/`addr`/`data_in`/`be`, load the counter with LATENCY-1, and go to WAIT.
  - WAIT: `busy`=1. Counter decrements each cycle. At count 0, perform the access and go to DONE.
  - DONE: `busy`=1, `done`=1 for exactly one cycle, then go to IDLE.
- Read: `data_out` loads the addressed word on the edge entering DONE. It holds that value until the next completed read. Writes and errors do not change it.
- Write: bytes with `be[i]`=1 are updated on the edge entering DONE; other bytes are untouched. `be`=0 completes normally with no change.
- `req` while `busy`=1 is ignored, not queued. The earliest back-to-back acceptance is the cycle after `done`.
- Memory contents are not reset and are undefined until written.
- Reset: state goes to IDLE; `busy`, `done`, `err`, `data_out` clear to 0; the counter clears. An in-flight write is discarded, but any word already written stays intact.

## Timing
- `req` sampled at edge E0. `busy` is high from E0 until E(LATENCY+1). `done`, `err`, and the new `data_out` are valid between E(LATENCY) and E(LATENCY+1).
- The write commits at E(LATENCY).
- Accept-to-accept period is LATENCY+2 cycles.
- A read-after-write to the same word, issued as the next request, returns the written data.
- Reset asserted mid-WAIT or mid-DONE takes effect immediately (asynchronous). The first request after reset deassertion is sampled at the first rising edge with `rst`=1.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined: an access with `addr[OFS-1:0]`≠0 runs the full latency and completes with `err`=1. There is no write and `data_out` is unchanged. `err`=0 on every other `done`, and `err`=0 whenever `done`=0.
- Not defined: the low OFS address bits are ignored, the access goes to the truncated word index, and `err` is tied to 0.

## Structure
- Package `dmem_pkg`:
  - state enum `{IDLE, WAIT, DONE}`;
  - `localparam` helpers for OFS and counter width (`$clog2(LATENCY)`, minimum 1).
- Sub-module `dmem_array`: a single-port synchronous array with DATA_WIDTH/8 byte-lane write enables and a synchronous read. The top level holds only the FSM, counter, request latches, and output registers.

## Test plan
- Reset, LATENCY=2, DATA_WIDTH=16: release `rst`; expect `busy`=`done`=`err`=0 and `data_out`=0x0000.
- Write 0xBEEF to addr 0x0010 with `be`=2'b11, then read 0x0010. Expect `done` 2 cycles after each acceptance, `busy` high for 3 cycles, and `data_out`=0xBEEF.
- Partial write: after the above, write 0x1234 with `be`=2'b01, then read. Expect 0xBE34.
- Ignored request: pulse `req` (read 0x0020) while `busy`=1. Expect no extra `done` and `data_out` unchanged.
- Misaligned write to 0x0011:
  - with `DMEM_ALIGN_CHECK_EN`, expect `err`=1 on `done`, and a read of 0x0010 still returns 0xBE34;
  - without the macro, expect `err`=0 and word 0x0010 written.
- Reset mid-WAIT during a write of 0xAAAA to 0x0010: outputs clear immediately. A later read of 0x0010 returns 0xBE34, and a LATENCY=1 rebuild gives a 3-cycle accept-to-accept period.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the multi-cycle data memory.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    // Byte-offset bits within one word.
    function automatic int ofs_of(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int cnt_width_of(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word array with byte-lane write enables and a
// registered read port (the read register is the memory's data output).
module dmem_array #(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH/8-1:0] we,
    input  logic                    re,
    input  logic [IDX_WIDTH-1:0]    idx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << IDX_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Contents are never reset so written words survive a reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    rdata <= '0;
        else if (re) rdata <= mem[idx];
    end

endmodule

// File: rtl/data_memory_mc.sv
// Multi-cycle data memory with req/done handshake and byte-enabled writes.
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module data_memory_mc
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic                    wr,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    err
);

    localparam int OFS       = ofs_of(DATA_WIDTH);
    localparam int CW        = cnt_width_of(LATENCY);
    localparam int IDX_WIDTH = ADDR_WIDTH - OFS;
    localparam int LANES     = DATA_WIDTH / 8;
    localparam logic [CW-1:0]         CNT_LOAD = CW'(LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((1 << OFS) - 1);

    state_t                  state, state_next;
    logic [CW-1:0]           cnt;
    logic                    wr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [LANES-1:0]        be_q;
    logic                    accept;
    logic                    access;
    logic                    mis;
    logic [LANES-1:0]        arr_we;
    logic                    arr_re;

    assign accept = (state == IDLE) && req;
    assign access = (state == WAIT) && (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = WAIT;
            WAIT:    if (cnt == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          cnt <= '0;
        else if (accept)                   cnt <= CNT_LOAD;
        else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
    end

    // Request fields are data only: they are qualified by the FSM state.
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q   <= wr;
            addr_q <= addr;
            data_q <= data_in;
            be_q   <= be;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign mis = (addr_q & LOW_MASK) != '0;

    // err is only ever high alongside done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err <= 1'b0;
        else      err <= access & mis;
    end
`else
    logic unused_low_addr;
    assign unused_low_addr = ^(addr_q & LOW_MASK);
    assign mis = 1'b0;
    assign err = 1'b0;
`endif

    assign arr_we = (access && wr_q && !mis) ? be_q : '0;
    assign arr_re = access && !wr_q && !mis;

    dmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .re    (arr_re),
        .idx   (addr_q[ADDR_WIDTH-1:OFS]),
        .wdata (data_q),
        .rdata (data_out)
    );

endmodule

// File: tb/tb_data_memory_mc.sv
// Directed, table-driven bench for data_memory_mc (LATENCY=2 main instance
// plus a LATENCY=1 instance for the accept-to-accept period).
module tb_data_memory_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] data_in = '0;
    logic [1:0]  be = '0;
    logic        busy, done, err;
    logic [15:0] data_out;

    logic        req1 = 1'b0;
    logic        wr1 = 1'b0;
    logic [15:0] addr1 = '0;
    logic [15:0] data_in1 = '0;
    logic [1:0]  be1 = '0;
    logic        busy1, done1, err1;
    logic [15:0] data_out1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_memory_mc #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .LATENCY(2)) u_dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr),
        .data_in(data_in), .be(be), .busy(busy), .done(done),
        .data_out(data_out), .err(err)
    );

    data_memory_mc #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req1), .wr(wr1), .addr(addr1),
        .data_in(data_in1), .be(be1), .busy(busy1), .done(done1),
        .data_out(data_out1), .err(err1)
    );

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [15:0] d;
        logic [1:0]  b;
        logic [15:0] exp_q;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One full transaction; returns edges from acceptance to done, plus err/data_out at done.
    task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input logic [1:0] b, output int lat, output logic e,
                          output logic [15:0] q, output logic busy_ok);
        @(negedge clk);
        req = 1'b1; wr = w; addr = a; data_in = d; be = b;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < 10) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = 99;
        if (!busy) busy_ok = 1'b0;
        e = err;
        q = data_out;
        @(posedge clk); #1;
        if (busy || done) busy_ok = 1'b0;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int          lat;
        logic        e, bok;
        logic [15:0] q;
        access(v.w, v.a, v.d, v.b, lat, e, q, bok);
        check({tag, " latency"}, lat, 2);
        check({tag, " busy window"}, bok, 1'b1);
        check({tag, " err"}, e, v.exp_err);
        check({tag, " data_out"}, q, v.exp_q);
    endtask

    vec_t vecs [10];

    initial begin
        int          lat, dn, t_done [$];
        logic        e, bok;
        logic [15:0] q;
        vec_t        v;

        vecs[0] = '{1'b1, 16'h0010, 16'hBEEF, 2'b11, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF, 1'b0};
        vecs[2] = '{1'b1, 16'h0010, 16'h1234, 2'b01, 16'hBEEF, 1'b0};
        vecs[3] = '{1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBE34, 1'b0};
        vecs[4] = '{1'b1, 16'h0020, 16'hC3C3, 2'b11, 16'hBE34, 1'b0};
        vecs[5] = '{1'b0, 16'h0020, 16'h0000, 2'b00, 16'hC3C3, 1'b0};
        vecs[6] = '{1'b1, 16'h0020, 16'hFFFF, 2'b00, 16'hC3C3, 1'b0};
        vecs[7] = '{1'b0, 16'h0020, 16'h0000, 2'b00, 16'hC3C3, 1'b0};
        vecs[8] = '{1'b1, 16'h0020, 16'h7700, 2'b10, 16'hC3C3, 1'b0};
        vecs[9] = '{1'b0, 16'h0020, 16'h0000, 2'b00, 16'h77C3, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset err", err, 1'b0);
        check("reset data_out", data_out, 16'h0000);

        for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Request pulsed while busy must be dropped
        @(negedge clk);
        req = 1'b1; wr = 1'b0; addr = 16'h0010;
        @(posedge clk); #1;
        addr = 16'h0020;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 0) req = 1'b0;
            if (done) dn++;
        end
        check("ignored req done count", dn, 1);
        check("ignored req data_out", data_out, 16'hBE34);

        // Misaligned write
        access(1'b1, 16'h0011, 16'h5566, 2'b11, lat, e, q, bok);
        check("misaligned latency", lat, 2);
`ifdef DMEM_ALIGN_CHECK_EN
        check("misaligned err", e, 1'b1);
        check("misaligned data_out", q, 16'h77C3);
        v = '{1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBE34, 1'b0};
`else
        check("misaligned err", e, 1'b0);
        v = '{1'b0, 16'h0010, 16'h0000, 2'b00, 16'h5566, 1'b0};
`endif
        run_vec("after misaligned", v);
        check("err low after done", err, 1'b0);
        v = '{1'b1, 16'h0010, 16'hBE34, 2'b11, v.exp_q, 1'b0};
        run_vec("restore", v);

        // Reset in the middle of WAIT drops the write
        @(negedge clk);
        req = 1'b1; wr = 1'b1; addr = 16'h0010; data_in = 16'hAAAA; be = 2'b11;
        @(posedge clk); #1;
        req = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("async reset busy", busy, 1'b0);
        check("async reset done", done, 1'b0);
        check("async reset err", err, 1'b0);
        check("async reset data_out", data_out, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        v = '{1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBE34, 1'b0};
        run_vec("post-reset read", v);

        // LATENCY=1 instance, request held high: period between dones
        @(negedge clk);
        req1 = 1'b1; wr1 = 1'b1; addr1 = 16'h0040; data_in1 = 16'h1357; be1 = 2'b11;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done1) t_done.push_back(c);
        end
        req1 = 1'b0;
        check("lat1 done count", t_done.size(), 4);
        if (t_done.size() >= 3) begin
            check("lat1 first done", t_done[0], 1);
            check("lat1 period a", t_done[1] - t_done[0], 3);
            check("lat1 period b", t_done[2] - t_done[1], 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
